// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Hits complete combinationally; misses run a writeback+refill line burst.
module dcache_line #(
  parameter int TAG_BITS  = 22,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [TAG_BITS-1:0]  wtag,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic                 wdirty,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [LINE_BITS-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dirty <= 1'b0;
      tag   <= '0;
    end else if (we) begin
      valid <= 1'b1;
      dirty <= wdirty;
      tag   <= wtag;
    end
  end

  always_ff @(posedge clk) begin
    if (we) data <= wdata;
  end
endmodule

module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int OFF_BITS  = $clog2(LINE_WORDS);
  localparam int TAG_BITS  = 30 - OFF_BITS - INDEX_BITS;
  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam logic [OFF_BITS-1:0] LAST = OFF_BITS'(LINE_WORDS - 1);

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] idx;
    logic [OFF_BITS-1:0]   word;
    logic [1:0]            byte_sel;
  } addr_t;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  addr_t req;
  assign req = cpu_addr;

  logic unused_byte_sel;
  assign unused_byte_sel = ^req.byte_sel;

  logic [NUM_LINES-1:0]                       line_valid, line_dirty;
  logic [NUM_LINES-1:0][TAG_BITS-1:0]         line_tag;
  logic [NUM_LINES-1:0][LINE_WORDS-1:0][31:0] line_data;

  state_t                      state;
  logic [OFF_BITS-1:0]         cnt;
  logic [TAG_BITS-1:0]         miss_tag;
  logic [INDEX_BITS-1:0]       miss_idx;
  logic [LINE_WORDS-1:0][31:0] fill_buf;

  logic                        hit, beat, last;
  logic [OFF_BITS-1:0]         cnt_nxt;
  logic                        wr_en, wr_dirty;
  logic [INDEX_BITS-1:0]       wr_idx;
  logic [TAG_BITS-1:0]         wr_tag;
  logic [LINE_WORDS-1:0][31:0] wr_data;

  assign hit       = cpu_req & line_valid[req.idx] & (line_tag[req.idx] == req.tag);
  assign beat      = mem_req & mem_ready;
  assign last      = (cnt == LAST);
  assign cnt_nxt   = cnt + 1'b1;
  assign cpu_ready = !rst && (state == IDLE) && hit;
  assign cpu_rdata = cpu_ready ? line_data[req.idx][req.word] : '0;

  // Single write port into the line array: store-hit merge or refill install.
  always_comb begin
    wr_en    = 1'b0;
    wr_dirty = 1'b0;
    wr_idx   = req.idx;
    wr_tag   = req.tag;
    wr_data  = line_data[req.idx];
    if (cpu_ready && cpu_we) begin
      wr_en    = 1'b1;
      wr_dirty = 1'b1;
      for (int b = 0; b < 4; b++)
        if (cpu_be[b]) wr_data[req.word][8*b +: 8] = cpu_wdata[8*b +: 8];
    end else if (!rst && state == REFILL && beat && last) begin
      wr_en       = 1'b1;
      wr_idx      = miss_idx;
      wr_tag      = miss_tag;
      wr_data     = fill_buf;
      wr_data[cnt] = mem_rdata;
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    dcache_line #(.TAG_BITS(TAG_BITS), .LINE_BITS(LINE_WORDS*32)) u_line (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_en && (wr_idx == INDEX_BITS'(i))),
      .wtag   (wr_tag),
      .wdata  (wr_data),
      .wdirty (wr_dirty),
      .valid  (line_valid[i]),
      .dirty  (line_dirty[i]),
      .tag    (line_tag[i]),
      .data   (line_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_buf  <= '0;
      miss_tag  <= '0;
      miss_idx  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req && !hit) begin
          miss_tag <= req.tag;
          miss_idx <= req.idx;
          cnt      <= '0;
          mem_req  <= 1'b1;
          if (line_valid[req.idx] && line_dirty[req.idx]) begin
            state     <= WB;
            mem_we    <= 1'b1;
            mem_addr  <= {line_tag[req.idx], req.idx, OFF_BITS'(0), 2'b00};
            mem_wdata <= line_data[req.idx][0];
          end else begin
            state     <= REFILL;
            mem_we    <= 1'b0;
            mem_addr  <= {req.tag, req.idx, OFF_BITS'(0), 2'b00};
            mem_wdata <= '0;
          end
        end
        WB: if (beat) begin
          if (last) begin
            state     <= REFILL;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= {miss_tag, miss_idx, OFF_BITS'(0), 2'b00};
            mem_wdata <= '0;
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= {line_tag[miss_idx], miss_idx, cnt_nxt, 2'b00};
            mem_wdata <= line_data[miss_idx][cnt_nxt];
          end
        end
        REFILL: if (beat) begin
          fill_buf[cnt] <= mem_rdata;
          if (last) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= {miss_tag, miss_idx, cnt_nxt, 2'b00};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller.
- Owns an array of 2^INDEX_BITS cacheline instances and sequences them between the CPU load/store port and a word-wide memory port.
- Hits are served combinationally.
- Misses are handled by a writeback+refill FSM that bursts whole lines one word per handshake.

Parameters:
- INDEX_BITS, 4: line index width; number of lines = 2^INDEX_BITS.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2; OFF_BITS = log2(LINE_WORDS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; held with all cpu_* stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  4  store byte enables
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid when cpu_ready
- cpu_ready  out  1  access completes this cycle
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = writeback beat, 0 = refill beat
- mem_addr  out  32  word-aligned beat address
- mem_wdata  out  32  writeback data
- mem_rdata  in  32  refill data, valid with mem_ready on a read beat
- mem_ready  in  1  beat accepted/completed this cycle

Behaviour:
- Address split:
  - tag = addr[31 : 2+OFF_BITS+INDEX_BITS]
  - idx = addr[2+OFF_BITS+INDEX_BITS-1 : 2+OFF_BITS]
  - word = addr[2+OFF_BITS-1 : 2]
  - Line data = LINE_WORDS×32 bits; word w occupies bits [32w+31 : 32w].
- hit = cpu_req & line[idx].valid & (line[idx].ctag == tag).
- Reset:
  - state IDLE, beat counter 0, refill buffer 0, all lines valid=0 / dirty=0.
  - cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
- States: IDLE, WB, REFILL.
- IDLE:
  - Load hit: cpu_ready=1 and cpu_rdata = selected word, in the same cycle.
  - Store hit: cpu_ready=1; at the clock edge line[idx] is written with the byte-merged word, dirty=1, tag unchanged.
  - Miss with victim valid & dirty: go to WB, counter=0.
  - Miss otherwise: go to REFILL, counter=0.
  - cpu_ready=0 on a miss.
  - cpu_rdata is 0 whenever cpu_ready=0.
- WB:
  - mem_req=1, mem_we=1, mem_addr = {victim ctag, idx, counter, 2'b00}, mem_wdata = victim word[counter].
  - Outputs are held stable until mem_ready.
  - On mem_ready: counter+1. On the last beat (counter == LINE_WORDS-1): counter=0, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, idx, counter, 2'b00}.
  - On mem_ready: mem_rdata is captured into buffer word[counter], counter+1.
  - On the last beat: line[idx] is written with the buffer (last word taken directly from mem_rdata), valid=1, dirty=0, ctag = req tag. Go to IDLE.
- The request is re-evaluated in IDLE after refill and hits; store data merges at that point, never during refill.
- Tag and idx for WB/REFILL are latched at miss detection. A cpu_addr change mid-miss does not corrupt the fill.
- cpu_req deasserted mid-miss: the burst completes and the line is installed; no cpu_ready results.
- mem_ready while mem_req=0 is ignored.
- Latency, zero-wait memory:
  - Clean miss: cpu_ready LINE_WORDS+1 cycles after the miss cycle.
  - Dirty miss: 2·LINE_WORDS+1 cycles after the miss cycle.
- Reset asserted mid-burst: the FSM aborts at the edge, all lines are invalidated, and mem_req=0 the following cycle.
- Only one line write per cycle; WB never modifies the line.

Test Plan:
- Reset, then load 0x0000_0040, mem_ready=1 always:
  - 4 read beats at 0x40, 0x44, 0x48, 0x4C.
  - cpu_ready 5 cycles after request.
  - cpu_rdata = mem word returned for 0x40.
- Load 0x44 after that fill: cpu_ready in the same cycle; no mem_req.
- Store 0x48, be=4'b0011, wdata=0xAAAA_BBBB, over old word 0x1122_3344:
  - Hit, cpu_ready same cycle.
  - A subsequent load of 0x48 returns 0x1122_BBBB.
- Load 0x0000_0440 (same idx 4, different tag) after the dirty store:
  - 4 write beats at 0x40..0x4C, with 0x48 data = 0x1122_BBBB.
  - Then 4 read beats at 0x440..0x44C.
  - cpu_ready 9 cycles after request.
- Refill with mem_ready asserted only every third cycle:
  - mem_addr/mem_req stay stable between acceptances.
  - Exactly LINE_WORDS beats; correct data installed.
- Assert rst during the second REFILL beat:
  - mem_req=0 the next cycle.
  - Re-access of the same address misses and refills from scratch.
